doublepulse_sequencer: RTL and testbench

Self-contained controller for double-pulse switching tests: holds a validated timing configuration, arms on a trigger edge, runs its own tick counter and drives the gate through a burst of N double-pulse shots separated by a programmable hold-off. It replaces the hand-wired pairing of a free counter with a double-pulse decoder. It also adds the config-validation, abort and burst sequencing that a test rig needs around a power stage.

---
 rtl/doublepulse_sequencer_if.sv | 41 ++++
 rtl/doublepulse_sequencer.sv | 156 +++++++++++++++
 tb/tb_doublepulse_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/doublepulse_sequencer_if.sv
// rtl/doublepulse_sequencer_if.sv - configuration, control and status bundle for the double-pulse sequencer
//
// Groups every non-clock/reset signal of doublepulse_sequencer.
//   master: test rig side; drives cfg_*, cfg_load, trigger and abort, and observes status.
//   slave : sequencer side; receives the configuration and control, and drives gate and status.
interface doublepulse_sequencer_if #(
    parameter int bitwidth  = 32,
    parameter int shotwidth = 8
);
    logic [bitwidth-1:0]  cfg_on1;
    logic [bitwidth-1:0]  cfg_off1;
    logic [bitwidth-1:0]  cfg_on2;
    logic [bitwidth-1:0]  cfg_off2;
    logic [bitwidth-1:0]  cfg_holdoff;
    logic [shotwidth-1:0] cfg_shots;
    logic                 cfg_load;
    logic                 cfg_error;
    logic                 cfg_valid;
    logic                 trigger;
    logic                 abort;
    logic                 gate_signal;
    logic                 busy;
    logic [bitwidth-1:0]  counter;
    logic [shotwidth-1:0] shots_remaining;
    logic                 shot_done;
    logic                 burst_done;

    modport master (
        output cfg_on1, cfg_off1, cfg_on2, cfg_off2, cfg_holdoff, cfg_shots, cfg_load,
        output trigger, abort,
        input  cfg_error, cfg_valid, gate_signal, busy, counter, shots_remaining,
        input  shot_done, burst_done
    );

    modport slave (
        input  cfg_on1, cfg_off1, cfg_on2, cfg_off2, cfg_holdoff, cfg_shots, cfg_load,
        input  trigger, abort,
        output cfg_error, cfg_valid, gate_signal, busy, counter, shots_remaining,
        output shot_done, burst_done
    );
endinterface

// File: rtl/doublepulse_sequencer.sv
// rtl/doublepulse_sequencer.sv - double-pulse burst controller with config validation, hold-off and abort
//
// Ports:
//   clock : system clock
//   reset : synchronous, active-high; clears all state including the active configuration
//   bus   : doublepulse_sequencer_if.slave
//           cfg_* / cfg_load       candidate timing and the strobe that captures it (IDLE only)
//           cfg_valid / cfg_error  active configuration present / last load rejected
//           trigger / abort        rising edge starts a burst / level forces IDLE
//           gate_signal            registered gate drive
//           busy, counter          sequencer activity and current tick / hold-off count
//           shots_remaining        shots left in the burst
//           shot_done, burst_done  single-cycle completion pulses
module doublepulse_sequencer #(
    parameter int bitwidth  = 32,
    parameter int shotwidth = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    doublepulse_sequencer_if.slave  bus
);
    localparam logic [1:0] st_idle    = 2'd0;
    localparam logic [1:0] st_pulse   = 2'd1;
    localparam logic [1:0] st_holdoff = 2'd2;

    localparam logic [bitwidth-1:0]  tick_one = {{(bitwidth-1){1'b0}}, 1'b1};
    localparam logic [shotwidth-1:0] shot_one = {{(shotwidth-1){1'b0}}, 1'b1};

    logic [1:0]           state;
    logic [bitwidth-1:0]  act_on1;
    logic [bitwidth-1:0]  act_off1;
    logic [bitwidth-1:0]  act_on2;
    logic [bitwidth-1:0]  act_off2;
    logic [bitwidth-1:0]  act_holdoff;
    logic [shotwidth-1:0] act_shots;
    logic [bitwidth-1:0]  counter_q;
    logic [shotwidth-1:0] shots_q;
    logic                 trigger_q;
    logic                 gate_q;
    logic                 shot_done_q;
    logic                 burst_done_q;
    logic                 cfg_valid_q;
    logic                 cfg_error_q;

    logic trig_edge;
    logic cfg_ok;
    logic in_window;

    assign trig_edge = bus.trigger & ~trigger_q;

    // Edges must be strictly increasing and a burst must contain at least one shot.
    assign cfg_ok = (bus.cfg_on1 < bus.cfg_off1) && (bus.cfg_off1 < bus.cfg_on2) &&
                    (bus.cfg_on2 < bus.cfg_off2) && (bus.cfg_shots != '0);

    // Half-open windows: the gate is high for exactly off-on ticks per window.
    assign in_window = ((counter_q >= act_on1) && (counter_q < act_off1)) ||
                       ((counter_q >= act_on2) && (counter_q < act_off2));

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= st_idle;
            act_on1      <= '0;
            act_off1     <= '0;
            act_on2      <= '0;
            act_off2     <= '0;
            act_holdoff  <= '0;
            act_shots    <= '0;
            counter_q    <= '0;
            shots_q      <= '0;
            trigger_q    <= 1'b0;
            gate_q       <= 1'b0;
            shot_done_q  <= 1'b0;
            burst_done_q <= 1'b0;
            cfg_valid_q  <= 1'b0;
            cfg_error_q  <= 1'b0;
        end else begin
            trigger_q    <= bus.trigger;
            gate_q       <= 1'b0;
            shot_done_q  <= 1'b0;
            burst_done_q <= 1'b0;

            if (bus.abort) begin
                // Abort outranks every same-cycle event; shots_remaining is left as-is.
                state     <= st_idle;
                counter_q <= '0;
            end else begin
                case (state)
                    st_idle: begin
                        if (bus.cfg_load) begin
                            // A load in the same cycle as a trigger edge wins; the edge is dropped.
                            if (cfg_ok) begin
                                act_on1     <= bus.cfg_on1;
                                act_off1    <= bus.cfg_off1;
                                act_on2     <= bus.cfg_on2;
                                act_off2    <= bus.cfg_off2;
                                act_holdoff <= bus.cfg_holdoff;
                                act_shots   <= bus.cfg_shots;
                                cfg_valid_q <= 1'b1;
                                cfg_error_q <= 1'b0;
                            end else begin
                                cfg_error_q <= 1'b1;
                            end
                        end else if (trig_edge && cfg_valid_q) begin
                            state     <= st_pulse;
                            counter_q <= '0;
                            shots_q   <= act_shots;
                        end
                    end

                    st_pulse: begin
                        gate_q <= in_window;
                        if (counter_q == act_off2) begin
                            shot_done_q <= 1'b1;
                            shots_q     <= shots_q - shot_one;
                            counter_q   <= '0;
                            if (shots_q == shot_one) begin
                                state        <= st_idle;
                                burst_done_q <= 1'b1;
                            end else if (act_holdoff == '0) begin
                                state <= st_pulse;
                            end else begin
                                state <= st_holdoff;
                            end
                        end else begin
                            counter_q <= counter_q + tick_one;
                        end
                    end

                    st_holdoff: begin
                        // Only entered with a non-zero hold-off, so holdoff-1 cannot underflow.
                        if (counter_q == act_holdoff - tick_one) begin
                            state     <= st_pulse;
                            counter_q <= '0;
                        end else begin
                            counter_q <= counter_q + tick_one;
                        end
                    end

                    default: begin
                        state     <= st_idle;
                        counter_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.gate_signal     = gate_q;
    assign bus.busy            = (state != st_idle);
    assign bus.counter         = counter_q;
    assign bus.shots_remaining = shots_q;
    assign bus.shot_done       = shot_done_q;
    assign bus.burst_done      = burst_done_q;
    assign bus.cfg_valid       = cfg_valid_q;
    assign bus.cfg_error       = cfg_error_q;
endmodule

// File: tb/tb_doublepulse_sequencer.sv
// tb/tb_doublepulse_sequencer.sv - scoreboard testbench for doublepulse_sequencer
module tb_doublepulse_sequencer;
    localparam int N = 8192;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    doublepulse_sequencer_if #(.bitwidth(32), .shotwidth(8)) dut_if ();

    doublepulse_sequencer #(.bitwidth(32), .shotwidth(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (dut_if)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    // Expected per-cycle outputs; cnt of -1 means "not checked".
    bit exp_gate [N];
    bit exp_busy [N];
    int exp_cnt  [N];
    int exp_sr   [N];
    bit exp_v    [N];
    bit exp_e    [N];

    typedef struct {
        int cyc;
        bit last;
        int sr;
    } done_t;
    done_t dq[$];

    // Reference model state
    int m_on1 = 0, m_off1 = 0, m_on2 = 0, m_off2 = 0, m_ho = 0, m_shots = 0;
    bit m_valid = 0, m_err = 0, m_trig = 0;
    int m_start = -1, m_busy_end = 0;

    // Candidate configuration driven on the bus
    int c_on1 = 0, c_off1 = 0, c_on2 = 0, c_off2 = 0, c_ho = 0, c_shots = 0;
    bit trig_lvl = 0;

    function automatic void fill_idle(int from, int cnt_v, int sr_v);
        for (int i = from; i < N; i++) begin
            exp_gate[i] = 0;
            exp_busy[i] = 0;
            exp_cnt[i]  = cnt_v;
            exp_sr[i]   = sr_v;
        end
    endfunction

    function automatic void fill_flags(int from, bit v, bit e);
        for (int i = from; i < N; i++) begin
            exp_v[i] = v;
            exp_e[i] = e;
        end
    endfunction

    function automatic void drop_after(int t);
        while (dq.size() > 0 && dq[dq.size()-1].cyc > t) void'(dq.pop_back());
    endfunction

    // Lay out a whole burst started by an edge sampled in cycle c.
    function automatic void schedule(int c);
        int s;
        int d;
        int idx;
        done_t e;
        s = c + 1;
        fill_idle(c + 1, -1, 0);
        for (int k = 0; k < m_shots; k++) begin
            for (int j = 0; j <= m_off2; j++) begin
                idx = s + j;
                if (idx + 1 < N) begin
                    exp_busy[idx] = 1;
                    exp_cnt[idx]  = j;
                    exp_sr[idx]   = m_shots - k;
                    if ((j >= m_on1 && j < m_off1) || (j >= m_on2 && j < m_off2))
                        exp_gate[idx + 1] = 1;
                end
            end
            d = s + m_off2 + 1;
            e.cyc  = d;
            e.last = (k == m_shots - 1);
            e.sr   = m_shots - k - 1;
            dq.push_back(e);
            if (d < N) exp_sr[d] = m_shots - k - 1;
            if (k == m_shots - 1) begin
                m_busy_end = d;
            end else begin
                for (int i = 0; i < m_ho; i++) begin
                    idx = d + i;
                    if (idx < N) begin
                        exp_busy[idx] = 1;
                        exp_cnt[idx]  = i;
                        exp_sr[idx]   = m_shots - k - 1;
                    end
                end
                s = d + m_ho;
            end
        end
    endfunction

    function automatic void model(int t, bit rst, bit load, bit trig, bit abt);
        bit idle;
        bit edge_seen;
        idle = !(t > m_start && t < m_busy_end);
        edge_seen = trig && !m_trig;
        if (rst) begin
            fill_idle(t + 1, 0, 0);
            fill_flags(t + 1, 0, 0);
            drop_after(t);
            m_valid = 0; m_err = 0; m_trig = 0;
            m_on1 = 0; m_off1 = 0; m_on2 = 0; m_off2 = 0; m_ho = 0; m_shots = 0;
            m_start = t; m_busy_end = t + 1;
            return;
        end
        m_trig = trig;
        if (abt) begin
            fill_idle(t + 1, 0, exp_sr[t]);
            drop_after(t);
            m_start = t; m_busy_end = t + 1;
        end else if (idle) begin
            if (load) begin
                if (c_on1 < c_off1 && c_off1 < c_on2 && c_on2 < c_off2 && c_shots != 0) begin
                    m_on1 = c_on1; m_off1 = c_off1; m_on2 = c_on2; m_off2 = c_off2;
                    m_ho = c_ho; m_shots = c_shots;
                    m_valid = 1; m_err = 0;
                end else begin
                    m_err = 1;
                end
                fill_flags(t + 1, m_valid, m_err);
            end else if (edge_seen && m_valid) begin
                m_start = t;
                schedule(t);
            end
        end
    endfunction

    task automatic drive(bit rst, bit load, bit trig, bit abt);
        int t;
        t = cyc;
        reset               = rst;
        dut_if.cfg_on1      = 32'(c_on1);
        dut_if.cfg_off1     = 32'(c_off1);
        dut_if.cfg_on2      = 32'(c_on2);
        dut_if.cfg_off2     = 32'(c_off2);
        dut_if.cfg_holdoff  = 32'(c_ho);
        dut_if.cfg_shots    = 8'(c_shots);
        dut_if.cfg_load     = load;
        dut_if.trigger      = trig;
        dut_if.abort        = abt;
        trig_lvl            = trig;
        model(t, rst, load, trig, abt);
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cycles(int n);
        for (int i = 0; i < n; i++) drive(0, 0, trig_lvl, 0);
    endtask

    task automatic set_cfg(int on1, int off1, int on2, int off2, int ho, int shots);
        c_on1 = on1; c_off1 = off1; c_on2 = on2; c_off2 = off2; c_ho = ho; c_shots = shots;
    endtask

    task automatic rand_cfg();
        c_on1   = $urandom_range(0, 8);
        c_off1  = c_on1 + $urandom_range(1, 8);
        c_on2   = c_off1 + $urandom_range(1, 6);
        c_off2  = c_on2 + $urandom_range(1, 8);
        c_ho    = $urandom_range(0, 6);
        c_shots = $urandom_range(1, 3);
        case ($urandom_range(0, 7))
            0: c_shots = 0;
            1: c_off1 = c_on1;
            2: c_on2 = c_off2;
            default: ;
        endcase
    endtask

    function automatic void chk(string name, int act, int exp, int t);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, t, act, exp);
        end
    endfunction

    // Monitor: compares the DUT against the model timeline and the done-event queue.
    always @(negedge clock) begin
        if (chk_en && cyc < N) begin
            int t;
            done_t e;
            t = cyc;
            chk("gate", int'(dut_if.gate_signal), int'(exp_gate[t]), t);
            chk("busy", int'(dut_if.busy), int'(exp_busy[t]), t);
            chk("shots_remaining", int'(dut_if.shots_remaining), exp_sr[t], t);
            chk("cfg_valid", int'(dut_if.cfg_valid), int'(exp_v[t]), t);
            chk("cfg_error", int'(dut_if.cfg_error), int'(exp_e[t]), t);
            if (exp_cnt[t] >= 0) chk("counter", int'(dut_if.counter), exp_cnt[t], t);
            if (dut_if.shot_done || dut_if.burst_done) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected cycle=%0d shot_done=%0d burst_done=%0d expected none",
                             t, dut_if.shot_done, dut_if.burst_done);
                end else begin
                    e = dq.pop_front();
                    if (e.cyc != t || !dut_if.shot_done || dut_if.burst_done != e.last ||
                        int'(dut_if.shots_remaining) != e.sr) begin
                        bad++;
                        $display("FAIL done_event cycle=%0d shot_done=%0d burst_done=%0d sr=%0d expected cycle=%0d burst_done=%0d sr=%0d",
                                 t, dut_if.shot_done, dut_if.burst_done, dut_if.shots_remaining,
                                 e.cyc, e.last, e.sr);
                    end
                end
            end else if (dq.size() > 0 && dq[0].cyc <= t) begin
                total++;
                bad++;
                e = dq.pop_front();
                $display("FAIL done_missing cycle=%0d actual=none expected shot_done at cycle=%0d", t, e.cyc);
            end
        end
    end

    initial begin
        reset = 1'b1;
        dut_if.cfg_on1 = '0; dut_if.cfg_off1 = '0; dut_if.cfg_on2 = '0; dut_if.cfg_off2 = '0;
        dut_if.cfg_holdoff = '0; dut_if.cfg_shots = '0; dut_if.cfg_load = 1'b0;
        dut_if.trigger = 1'b0; dut_if.abort = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_gate[i] = 0; exp_busy[i] = 0; exp_cnt[i] = 0; exp_sr[i] = 0;
            exp_v[i] = 0; exp_e[i] = 0;
        end
        @(posedge clock);
        #1;
        drive(1, 0, 0, 0);
        chk_en = 1;
        drive(0, 0, 0, 0);

        // Rejected load with no prior config, then an ignored trigger, then a good load.
        set_cfg(10, 5, 15, 30, 5, 2);
        drive(0, 1, 0, 0);
        wait_cycles(2);
        drive(0, 0, 1, 0);
        wait_cycles(5);
        drive(0, 0, 0, 0);
        set_cfg(3, 10, 15, 30, 5, 2);
        drive(0, 1, 0, 0);
        wait_cycles(2);

        // Two-shot burst with trigger held high, a mid-burst edge and mid-burst loads.
        drive(0, 0, 1, 0);
        wait_cycles(20);
        drive(0, 0, 0, 0);
        drive(0, 0, 1, 0);
        set_cfg(1, 2, 3, 4, 1, 1);
        drive(0, 1, 1, 0);
        set_cfg(9, 2, 3, 4, 1, 1);
        drive(0, 1, 1, 0);
        wait_cycles(60);
        drive(0, 0, 0, 0);
        wait_cycles(3);

        // Zero hold-off, three shots back to back.
        set_cfg(2, 4, 6, 9, 0, 3);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        wait_cycles(40);

        // Abort while counter is 20 in the first shot, then a full restart.
        set_cfg(3, 10, 15, 30, 5, 2);
        drive(0, 1, 0, 0);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        wait_cycles(19);
        drive(0, 0, 0, 1);
        wait_cycles(3);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        wait_cycles(75);

        // Reset in the middle of a hold-off; a following edge has no config to run.
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        wait_cycles(32);
        drive(1, 0, 0, 0);
        wait_cycles(2);
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);
        wait_cycles(10);

        // Randomised traffic.
        for (int r = 0; r < 15; r++) begin
            rand_cfg();
            drive(0, 1, 0, 0);
            for (int i = 0; i < 150; i++) begin
                bit trig;
                bit load;
                bit abt;
                bit rst;
                trig = trig_lvl;
                if ($urandom_range(0, 7) == 0) trig = ~trig;
                abt  = ($urandom_range(0, 99) == 0);
                load = !abt && ($urandom_range(0, 39) == 0);
                rst  = ($urandom_range(0, 399) == 0);
                if (load) rand_cfg();
                if (cyc < N - 400) drive(rst, load, trig, abt);
            end
        end

        drive(0, 0, 0, 0);
        for (int i = 0; i < 300 && cyc < N - 2; i++) drive(0, 0, 0, 0);
        @(negedge clock);
        chk_en = 0;
        chk("pending_done_events", dq.size(), 0, cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
